// File: rtl/keyprov_bus_master.sv
// rtl/keyprov_bus_master.sv - single-word initiator for the secure storage register target, write-verify with bounded retry
// Optional key write-lock is compiled in with `define KEYPROV_LOCK_EN.
module keyprov_bus_master #(
  parameter logic [7:0]  KEY_ADDR  = 8'h10,
  parameter logic [7:0]  ID_ADDR   = 8'h11,
  parameter logic [7:0]  CTRL_ADDR = 8'h12,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic [2:0]  rsp_retries,
  output logic [7:0]  m_address,
  output logic [31:0] m_write_data,
  output logic        m_write_enable,
  input  logic [31:0] m_read_data,
  output logic        key_locked
);

`ifdef KEYPROV_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_VFY_FAIL = 2'b01;
  localparam logic [1:0] ST_ADDR_ERR = 2'b10;
  localparam logic [1:0] ST_LOCKED   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [2:0]  rsp_retries_q, rsp_retries_d;
  logic [7:0]  m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        m_we_q, m_we_d;
  logic        lock_q, lock_d;

  logic addr_ok, lock_hit, match;

  assign addr_ok  = (req_addr == KEY_ADDR) || (req_addr == ID_ADDR) || (req_addr == CTRL_ADDR);
  assign lock_hit = LOCK_EN && lock_q && (req_addr == KEY_ADDR);
  // The control register only implements bit 0, so only that bit can be verified.
  assign match    = (addr_q == CTRL_ADDR) ? (m_read_data[0] == wdata_q[0])
                                          : (m_read_data == wdata_q);

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_status_d  = rsp_status_q;
    rsp_retries_d = rsp_retries_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    lock_d        = lock_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 3'd0;
          if (!addr_ok || lock_hit) begin
            state_d       = S_RESP;
            rsp_status_d  = addr_ok ? ST_LOCKED : ST_ADDR_ERR;
            rsp_rdata_d   = 32'h0;
            rsp_retries_d = 3'd0;
          end else begin
            state_d  = req_write ? S_WRITE : S_READ;
            m_addr_d = req_addr;
            if (req_write) m_wdata_d = req_wdata;
          end
        end
      end
      S_WRITE: state_d = S_READ;
      S_READ: begin
        rsp_rdata_d   = m_read_data;
        rsp_retries_d = cnt_q;
        if (!write_q || match) begin
          state_d      = S_RESP;
          rsp_status_d = ST_OK;
          if (write_q && addr_q == KEY_ADDR) lock_d = LOCK_EN;
        end else if (cnt_q < MAX_R) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_WRITE;
        end else begin
          state_d      = S_RESP;
          rsp_status_d = ST_VFY_FAIL;
        end
      end
      S_RESP: if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    m_we_d      = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      addr_q        <= 8'h0;
      wdata_q       <= 32'h0;
      cnt_q         <= 3'd0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_status_q  <= 2'b00;
      rsp_retries_q <= 3'd0;
      m_addr_q      <= 8'h0;
      m_wdata_q     <= 32'h0;
      m_we_q        <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_status_q  <= rsp_status_d;
      rsp_retries_q <= rsp_retries_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_we_q        <= m_we_d;
      lock_q        <= lock_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_retries    = rsp_retries_q;
  assign m_address      = m_addr_q;
  assign m_write_data   = m_wdata_q;
  assign m_write_enable = m_we_q;
  assign key_locked     = lock_q;

endmodule

// File: tb/tb_keyprov_bus_master.sv
// tb/tb_keyprov_bus_master.sv - directed self-checking bench for keyprov_bus_master
module tb_keyprov_bus_master;

`ifdef KEYPROV_LOCK_EN
  localparam logic LOCK_EXP = 1'b1;
`else
  localparam logic LOCK_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_retries;
  logic [7:0]  m_address;
  logic [31:0] m_write_data;
  logic        m_write_enable;
  logic [31:0] m_read_data;
  logic        key_locked;

  keyprov_bus_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .m_address(m_address), .m_write_data(m_write_data),
    .m_write_enable(m_write_enable), .m_read_data(m_read_data),
    .key_locked(key_locked)
  );

  always #5 clk = ~clk;

  // Storage target model: ctrl keeps bit 0 only; ignore_w makes it drop writes.
  logic [31:0] t_key  = 32'h0;
  logic [31:0] t_id   = 32'h1234_5678;
  logic [31:0] t_ctrl = 32'h0;
  logic        ignore_w = 1'b0;
  int          we_cnt = 0;

  always_comb begin
    case (m_address)
      8'h10:   m_read_data = t_key;
      8'h11:   m_read_data = t_id;
      8'h12:   m_read_data = t_ctrl;
      default: m_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (m_write_enable) begin
      we_cnt <= we_cnt + 1;
      if (!ignore_w) begin
        case (m_address)
          8'h10:   t_key  <= m_write_data;
          8'h11:   t_id   <= m_write_data;
          8'h12:   t_ctrl <= {31'b0, m_write_data[0]};
          default: ;
        endcase
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_wait", {31'b0, (n < 20)}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clk);
    chk({tag, "_rsp_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_req_ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_status"}, {30'b0, rsp_status}, 32'd0);
    chk({tag, "_rsp_retries"}, {29'b0, rsp_retries}, 32'd0);
    chk({tag, "_m_address"}, {24'b0, m_address}, 32'd0);
    chk({tag, "_m_write_data"}, m_write_data, 32'd0);
    chk({tag, "_m_we"}, {31'b0, m_write_enable}, 32'd0);
    chk({tag, "_key_locked"}, {31'b0, key_locked}, 32'd0);
  endtask

  initial begin
    int lat;
    int w0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Read ID
    w0 = we_cnt;
    issue(1'b0, 8'h11, 32'h0);
    wait_rsp(lat);
    chk("rd_id_lat", lat, 32'd2);
    chk("rd_id_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_id_status", {30'b0, rsp_status}, 32'd0);
    chk("rd_id_retries", {29'b0, rsp_retries}, 32'd0);
    chk("rd_id_we", we_cnt - w0, 32'd0);
    finish_rsp("rd_id");

    // Write KEY to a well-behaved target
    w0 = we_cnt;
    issue(1'b1, 8'h10, 32'hA5A5_0001);
    chk("wr_key_we_pulse", {31'b0, m_write_enable}, 32'd1);
    chk("wr_key_addr", {24'b0, m_address}, 32'h10);
    chk("wr_key_wdata", m_write_data, 32'hA5A5_0001);
    wait_rsp(lat);
    chk("wr_key_lat", lat, 32'd3);
    chk("wr_key_status", {30'b0, rsp_status}, 32'd0);
    chk("wr_key_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("wr_key_we", we_cnt - w0, 32'd1);
    chk("wr_key_locked", {31'b0, key_locked}, {31'b0, LOCK_EXP});
    finish_rsp("wr_key");

    // Write CTRL: only bit 0 is stored and compared
    w0 = we_cnt;
    issue(1'b1, 8'h12, 32'hFFFF_FFFE);
    wait_rsp(lat);
    chk("wr_ctrl_lat", lat, 32'd3);
    chk("wr_ctrl_status", {30'b0, rsp_status}, 32'd0);
    chk("wr_ctrl_rdata", rsp_rdata, 32'h0);
    chk("wr_ctrl_we", we_cnt - w0, 32'd1);
    finish_rsp("wr_ctrl");

    // Write ID to a target that ignores writes: 1 + 2 retries then VERIFY_FAIL
    ignore_w = 1'b1;
    w0 = we_cnt;
    issue(1'b1, 8'h11, 32'hDEAD_BEEF);
    wait_rsp(lat);
    chk("vfy_lat", lat, 32'd7);
    chk("vfy_status", {30'b0, rsp_status}, 32'd1);
    chk("vfy_retries", {29'b0, rsp_retries}, 32'd2);
    chk("vfy_rdata", rsp_rdata, 32'h1234_5678);
    chk("vfy_we", we_cnt - w0, 32'd3);
    finish_rsp("vfy");
    ignore_w = 1'b0;

    // Bad address with response back-pressure
    rsp_ready = 1'b0;
    w0 = we_cnt;
    issue(1'b1, 8'h13, 32'h5555_AAAA);
    wait_rsp(lat);
    chk("aerr_lat", lat, 32'd1);
    chk("aerr_status", {30'b0, rsp_status}, 32'd2);
    chk("aerr_rdata", rsp_rdata, 32'h0);
    chk("aerr_retries", {29'b0, rsp_retries}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("aerr_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("aerr_hold_status", {30'b0, rsp_status}, 32'd2);
      chk("aerr_hold_rdata", rsp_rdata, 32'h0);
      chk("aerr_hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    chk("aerr_we", we_cnt - w0, 32'd0);
    chk("aerr_addr_held", {24'b0, m_address}, 32'h11);
    rsp_ready = 1'b1;
    finish_rsp("aerr");

`ifdef KEYPROV_LOCK_EN
    w0 = we_cnt;
    issue(1'b1, 8'h10, 32'h0);
    wait_rsp(lat);
    chk("lk_wr_lat", lat, 32'd1);
    chk("lk_wr_status", {30'b0, rsp_status}, 32'd3);
    chk("lk_wr_rdata", rsp_rdata, 32'h0);
    finish_rsp("lk_wr");
    issue(1'b0, 8'h10, 32'h0);
    wait_rsp(lat);
    chk("lk_rd_lat", lat, 32'd1);
    chk("lk_rd_status", {30'b0, rsp_status}, 32'd3);
    chk("lk_rd_rdata", rsp_rdata, 32'h0);
    chk("lk_we", we_cnt - w0, 32'd0);
    chk("lk_key_locked", {31'b0, key_locked}, 32'd1);
    finish_rsp("lk_rd");
`else
    issue(1'b0, 8'h10, 32'h0);
    wait_rsp(lat);
    chk("key_rd_lat", lat, 32'd2);
    chk("key_rd_status", {30'b0, rsp_status}, 32'd0);
    chk("key_rd_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("key_rd_locked", {31'b0, key_locked}, 32'd0);
    finish_rsp("key_rd");
`endif

    // Reset in the middle of a WRITE cycle
    issue(1'b1, 8'h11, 32'h0BAD_F00D);
    chk("mid_we", {31'b0, m_write_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 8'h11, 32'h0);
    wait_rsp(lat);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_rdata", rsp_rdata, 32'h1234_5678);
    finish_rsp("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keyprov_bus_master.md
Name: keyprov_bus_master

Overview:
- Initiator for the secure storage register target: accepts single-word read/write commands over a valid/ready request channel and drives the target's address/write_data/write_enable bus.
- Samples the target's combinational read_data and returns it on a valid/ready response channel.
- Every write is verified by readback, with bounded retry; addresses outside the three defined registers are rejected without any bus activity.
- Sits between the provisioning/boot controller and the storage target.

Parameters:
- KEY_ADDR, 8'h10, encryption key register address
- ID_ADDR, 8'h11, device ID register address
- CTRL_ADDR, 8'h12, access control register address (bit 0 only significant)
- MAX_RETRY, 2, write+verify re-attempts after a first mismatch (0..7)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when high with req_valid
- req_write  input  1  1=write, 0=read
- req_addr  input  8  target register address
- req_wdata  input  32  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_rdata  output  32  read or readback value
- rsp_status  output  2  00 OK, 01 VERIFY_FAIL, 10 ADDR_ERR, 11 LOCKED
- rsp_retries  output  3  retries consumed for this command
- m_address  output  8  to target address
- m_write_data  output  32  to target write_data
- m_write_enable  output  1  to target write_enable
- m_read_data  input  32  from target read_data (combinational on m_address)
- key_locked  output  1  key register write-locked

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_status=0, rsp_retries=0, m_address=0, m_write_data=0, m_write_enable=0, key_locked=0. All outputs are registered.
- Reset asserted mid-operation aborts the command immediately: the bus returns to idle values, no response is produced, and the lock clears.
- FSM states are IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, addr and wdata; req_ready=0 from the next cycle.
  - If addr is not one of KEY/ID/CTRL: go to RESP with ADDR_ERR, rdata=0, no bus activity.
  - Else if write: go to WRITE. Else: go to READ.
- WRITE:
  - Exactly one cycle with m_write_enable=1, m_address=addr, m_write_data=wdata.
  - Next state is READ.
- READ:
  - One cycle with m_write_enable=0 and m_address=addr.
  - m_read_data is captured at the closing edge.
  - Read command: rsp_rdata=captured value, status OK, go to RESP.
  - Write command: compare captured value with wdata. Compare bit 0 only for CTRL_ADDR; compare all 32 bits otherwise.
    - Match: status OK, go to RESP.
    - Mismatch with retry count < MAX_RETRY: increment the count and go to WRITE.
    - Mismatch with retry count = MAX_RETRY: status VERIFY_FAIL, go to RESP.
  - rsp_rdata always carries the last readback value.
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_status and rsp_retries stay stable until rsp_ready.
  - The cycle rsp_valid&&rsp_ready is seen, go to IDLE. rsp_valid=0 and req_ready=1 from the next cycle.
  - rsp_ready held high continuously is legal.
- Latency with rsp_ready=1 (accept edge to rsp_valid high):
  - read: 2 cycles
  - write, no retry: 3 cycles
  - ADDR_ERR: 1 cycle
  - each retry adds 2 cycles
- Outside WRITE, m_write_enable is 0 and m_address holds the last value. m_address is driven in IDLE only after reset.
- Only one command is in flight at a time; there is no request buffering.

Optional Feature:
- Macro: KEYPROV_LOCK_EN.
- Defined:
  - A write to KEY_ADDR that completes with OK sets key_locked=1, effective from the RESP cycle.
  - While locked, any later read or write to KEY_ADDR goes IDLE->RESP with status LOCKED, rdata=0 and no bus activity.
  - The lock clears only on rst_n.
  - ID_ADDR and CTRL_ADDR are unaffected.
- Not defined: key_locked is tied 0 and status LOCKED is never produced.

Test Plan:
- Read ID_ADDR, target holds 32'h12345678, rsp_ready=1 -> no write_enable pulse; rsp_valid 2 cycles after accept with rdata 32'h12345678, status 00, retries 0.
- Write KEY_ADDR 32'hA5A5_0001 to a well-behaved target -> one m_write_enable pulse at addr 8'h10, then a readback cycle; rsp status 00, rdata 32'hA5A5_0001, rsp_valid 3 cycles after accept.
- Write CTRL_ADDR 32'hFFFF_FFFE with the target returning {31'b0,wdata[0]} -> status 00 (bit-0 compare), rdata 32'h0.
- Write ID_ADDR with the target model ignoring writes, MAX_RETRY=2 -> exactly 3 write_enable pulses; status 01, retries 2.
- req_addr 8'h13, then rsp_ready held low for 5 cycles -> no bus activity; rsp_valid held with status 10 and stable fields; req_ready returns 1 the cycle after rsp_ready.
- With KEYPROV_LOCK_EN defined: successful KEY write, then KEY write 32'h0 and KEY read -> key_locked=1; both later commands return status 11, rdata 0, no write_enable. Assert rst_n low mid-WRITE -> all outputs return to reset values, key_locked=0.
